// File: rtl/mul_seq_if.sv
//==============================================================================
// Module      : mul_seq_if
// Description : Operand/product handshake bundle for the iterative multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               A_signed;
    logic               B_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;

    modport master (
        output in_valid, A, B, A_signed, B_signed, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, A_signed, B_signed, out_ready,
        output in_ready, out_valid, P
    );
endinterface

`default_nettype wire

// File: rtl/mul_seq.sv
//==============================================================================
// Module      : mul_seq
// Description : Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits
//               per clock, per-operand signed mode, full 2*WIDTH product.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire       clk,
    input  wire       rst,
    mul_seq_if.slave  bus
);
    localparam int              c_n    = WIDTH / BITS_PER_CYCLE;
    localparam int              c_cw   = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [c_cw-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_p;

    logic                               w_neg_a;
    logic                               w_neg_b;
    logic [WIDTH-1:0]                   w_abs_a;
    logic [WIDTH-1:0]                   w_abs_b;
    logic [WIDTH+BITS_PER_CYCLE-1:0]    w_pp;
    logic [WIDTH+BITS_PER_CYCLE-1:0]    w_sum;
    logic [2*WIDTH+BITS_PER_CYCLE-1:0]  w_cat;
    logic [2*WIDTH-1:0]                 w_acc_nxt;
    logic [2*WIDTH-1:0]                 w_prod;
    logic                               w_unused_lo;

    // An operand counts as negative only when its mode says signed.
    assign w_neg_a = bus.A_signed & bus.A[WIDTH-1];
    assign w_neg_b = bus.B_signed & bus.B[WIDTH-1];
    assign w_abs_a = w_neg_a ? -bus.A : bus.A;
    assign w_abs_b = w_neg_b ? -bus.B : bus.B;

    // Upper half plus partial product never exceeds WIDTH+BITS_PER_CYCLE bits.
    assign w_pp      = {{WIDTH{1'b0}}, r_b[BITS_PER_CYCLE-1:0]} * {{BITS_PER_CYCLE{1'b0}}, r_a};
    assign w_sum     = {{BITS_PER_CYCLE{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
    assign w_cat     = {w_sum, r_acc[WIDTH-1:0]};
    assign w_acc_nxt = w_cat[2*WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_unused_lo = ^w_cat[BITS_PER_CYCLE-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_a     <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_neg   <= w_neg_a ^ w_neg_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_busy;
                    end
                end
                c_busy: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b >> BITS_PER_CYCLE;
                    r_cnt <= r_cnt + c_cw'(1);
                    if (r_cnt == c_last) begin
                        r_p     <= w_prod;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_idle);
    assign bus.out_valid = (r_state == c_done);
    assign bus.P         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
//==============================================================================
// Module      : tb_mul_seq
// Description : Directed and random checks of mul_seq against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_seq;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    mul_seq_if #(.WIDTH(32)) bus32 ();
    mul_seq_if #(.WIDTH(8))  bus8  ();

    mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    mul_seq #(.WIDTH(8),  .BITS_PER_CYCLE(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product of the mode-extended operands, truncated to the product width.
    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic sa, input logic sb);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = sa ? {{8{a[7]}}, a} : {8'd0, a};
        eb = sb ? {{8{b[7]}}, b} : {8'd0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sa,
                         input logic sb, input string tag, output logic [63:0] p_obs);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
        bus32.A = a; bus32.B = b; bus32.A_signed = sa; bus32.B_signed = sb;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b0;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        p_obs = bus32.P;
        check({tag, "_P"}, bus32.P, ref32(a, b, sa, sb));
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(bus32.out_valid), 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sa, input logic sb);
        int lat;
        @(negedge clk);
        bus8.A = a; bus8.B = b; bus8.A_signed = sa; bus8.B_signed = sb;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", 64'(lat), 64'd3);
        check("w8_P", 64'(bus8.P), 64'(ref8(a, b, sa, sb)));
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.A = '0; bus32.B = '0;
        bus32.A_signed = 1'b0; bus32.B_signed = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.A = '0; bus8.B = '0;
        bus8.A_signed = 1'b0; bus8.B_signed = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(bus32.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus32.out_valid), 64'd0);
        check("reset_P", bus32.P, 64'd0);
        rst = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            run32(32'(i), 32'(11 - i), 1'b0, 1'b0, "sweep", p);
            check("sweep_const", p, 64'(i * (11 - i)));
        end

        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "umax", p);
        check("umax_const", p, 64'hFFFFFFFE00000001);
        check("umax_low", 64'(p[31:0]), 64'h1);
        run32(32'h80000000, 32'h80000000, 1'b1, 1'b1, "smin", p);
        check("smin_const", p, 64'h4000000000000000);
        run32(32'hFFFFFFFF, 32'd7, 1'b1, 1'b1, "neg1_ss", p);
        check("neg1_ss_const", p, 64'hFFFFFFFFFFFFFFF9);
        run32(32'hFFFFFFFF, 32'd7, 1'b1, 1'b0, "neg1_su", p);
        check("neg1_su_const", p, 64'hFFFFFFFFFFFFFFF9);
        run32(32'hFFFFFFFF, 32'd7, 1'b0, 1'b0, "neg1_uu", p);
        check("neg1_uu_const", p, 64'h00000006FFFFFFF9);
        run32(32'd0, 32'hFFFFFFFB, 1'b1, 1'b1, "zero_neg", p);
        check("zero_neg_const", p, 64'd0);
        run32(32'd9, 32'h80000000, 1'b0, 1'b1, "mixed_us", p);

        // Backpressure with noise on the input side while busy and done.
        ra = $urandom; rb = $urandom;
        exp = ref32(ra, rb, 1'b1, 1'b0);
        @(negedge clk);
        bus32.A = ra; bus32.B = rb; bus32.A_signed = 1'b1; bus32.B_signed = 1'b0;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!bus32.out_valid && lat < 100) begin
            check("bp_busy_in_ready", 64'(bus32.in_ready), 64'd0);
            bus32.in_valid = 1'($urandom); bus32.A = $urandom; bus32.B = $urandom;
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd33);
        repeat (5) begin
            check("bp_out_valid", 64'(bus32.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
            check("bp_P", bus32.P, exp);
            bus32.in_valid = 1'($urandom); bus32.A = $urandom; bus32.B = $urandom;
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        check("bp_P_release", bus32.P, exp);
        @(negedge clk);
        bus32.out_ready = 1'b0;
        check("bp_done_out_valid", 64'(bus32.out_valid), 64'd0);
        check("bp_done_in_ready", 64'(bus32.in_ready), 64'd1);
        check("bp_P_retained", bus32.P, exp);

        // Reset ten cycles into an operation.
        bus32.A = 32'd1234; bus32.B = 32'd5678; bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("midrst_P", bus32.P, 64'd0);
        check("midrst_in_ready", 64'(bus32.in_ready), 64'd1);
        run32(32'd3, 32'hFFFFFFFC, 1'b1, 1'b1, "after_rst", p);
        check("after_rst_const", p, 64'hFFFFFFFFFFFFFFF4);

        // in_valid left high across a completion is taken again on idle.
        exp = ref32(32'd77, 32'd1001, 1'b0, 1'b0);
        @(negedge clk);
        bus32.A = 32'd77; bus32.B = 32'd1001; bus32.A_signed = 1'b0; bus32.B_signed = 1'b0;
        bus32.in_valid = 1'b1;
        lat = 0;
        while (!bus32.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_P1", bus32.P, exp);
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        check("hold_idle_in_ready", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        check("hold_reaccept", 64'(bus32.in_ready), 64'd0);
        lat = 0;
        while (!bus32.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_P2", bus32.P, exp);
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.out_ready = 1'b0;

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            run32(ra, rb, 1'($urandom), 1'($urandom), "rand32", p);
        end

        run8(8'h80, 8'h80, 1'b1, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0, 1'b0);
        run8(8'hFF, 8'h07, 1'b1, 1'b0);
        run8(8'h00, 8'h81, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
